// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready handshakes.
// One instruction is held at a time; it is issued downstream only when none of
// the registers it reads or writes has a write still in flight. In-flight
// writes are tracked in a per-register pending scoreboard, cleared by the
// writeback port.
module decode_stage #(
    parameter int INST_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] INST,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] DR,
    output logic [REG_AW-1:0] SA,
    output logic [REG_AW-1:0] SB,
    output logic [IMM_W-1:0]  IMM,
    output logic              MB,
    output logic [2:0]        FS,
    output logic              MD,
    output logic              LD,
    output logic              MW,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_addr,
    output logic [CNT_W-1:0]  stall_count
);

    localparam int NREG   = 2 ** REG_AW;
    // Field layout: opcode in the top nibble, then DR, SA, SB packed downward.
    // INST_W must be at least 4 + 3*REG_AW and at least IMM_W.
    localparam int OP_LSB = INST_W - 4;
    localparam int DR_LSB = OP_LSB - REG_AW;
    localparam int SA_LSB = DR_LSB - REG_AW;
    localparam int SB_LSB = SA_LSB - REG_AW;

    // Combinational decode of the incoming instruction.
    logic [3:0] w_op;
    logic [2:0] w_fs;
    logic       w_mb, w_md, w_ld, w_mw, w_ra, w_rb;

    // Registered (held) decode results.
    logic              r_held;
    logic [REG_AW-1:0] r_dr, r_sa, r_sb;
    logic [IMM_W-1:0]  r_imm;
    logic [2:0]        r_fs;
    logic              r_mb, r_md, r_ld, r_mw, r_ra, r_rb;
    logic [NREG-1:0]   r_pend;
    logic [CNT_W-1:0]  r_stall_count;

    // Handshake / scoreboard wires.
    logic [NREG-1:0] w_retire;
    logic [NREG-1:0] w_claim;
    logic [NREG-1:0] w_eff;
    logic            w_hazard;
    logic            w_out_valid;
    logic            w_issue;
    logic            w_in_ready;
    logic            w_accept;

    assign w_op = INST[INST_W-1 -: 4];

    // Opcode decode: NOP, ALU reg (0fff), ALU imm (1fff), LOAD (1110), STORE (1111).
    always_comb begin
        w_fs = 3'b000;
        w_mb = 1'b0;
        w_md = 1'b0;
        w_ld = 1'b0;
        w_mw = 1'b0;
        w_ra = 1'b0;
        w_rb = 1'b0;
        if (w_op == 4'b0000) begin
            // NOP: no controls, no register traffic.
        end else if (!w_op[3]) begin
            w_fs = w_op[2:0];
            w_ld = 1'b1;
            w_ra = 1'b1;
            w_rb = 1'b1;
        end else if (w_op[2:1] != 2'b11) begin
            w_fs = w_op[2:0];
            w_mb = 1'b1;
            w_ld = 1'b1;
            w_ra = 1'b1;
        end else if (!w_op[0]) begin
            w_mb = 1'b1;
            w_md = 1'b1;
            w_ld = 1'b1;
            w_ra = 1'b1;
        end else begin
            w_mb = 1'b1;
            w_mw = 1'b1;
            w_ra = 1'b1;
            w_rb = 1'b1;
        end
    end

    // A writeback in the current cycle already counts as retired for the
    // hazard check, so a dependent instruction can issue in the same cycle.
    assign w_eff       = r_pend & ~w_retire;
    assign w_hazard    = r_held & ((r_ra & w_eff[r_sa]) |
                                   (r_rb & w_eff[r_sb]) |
                                   (r_ld & w_eff[r_dr]));
    assign w_out_valid = r_held & ~w_hazard;
    assign w_issue     = w_out_valid & out_ready;
    // flush blocks the accept so a fresh instruction is not lost to the clear.
    assign w_in_ready  = ~flush & (~r_held | w_issue);
    assign w_accept    = in_valid & w_in_ready;

    // Per-register pending bits: an issuing write claims the register, a
    // writeback releases it; a claim and release in the same cycle keeps it
    // pending because the new write is the younger one.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_pend
            assign w_retire[gi] = wb_valid & (wb_addr == REG_AW'(gi));
            assign w_claim[gi]  = w_issue & r_ld & (r_dr == REG_AW'(gi));

            // Pending-write flag for register gi.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_pend[gi] <= 1'b0;
                end else if (w_claim[gi]) begin
                    r_pend[gi] <= 1'b1;
                end else if (w_retire[gi]) begin
                    r_pend[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    // Holding-register occupancy: flush wins, then a new accept, then issue drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_held <= 1'b0;
        end else if (flush) begin
            r_held <= 1'b0;
        end else if (w_accept) begin
            r_held <= 1'b1;
        end else if (w_issue) begin
            r_held <= 1'b0;
        end
    end

    // Decoded control word, loaded only on accept so it stays stable while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dr  <= '0;
            r_sa  <= '0;
            r_sb  <= '0;
            r_imm <= '0;
            r_fs  <= 3'b000;
            r_mb  <= 1'b0;
            r_md  <= 1'b0;
            r_ld  <= 1'b0;
            r_mw  <= 1'b0;
            r_ra  <= 1'b0;
            r_rb  <= 1'b0;
        end else if (w_accept) begin
            r_dr  <= INST[DR_LSB +: REG_AW];
            r_sa  <= INST[SA_LSB +: REG_AW];
            r_sb  <= INST[SB_LSB +: REG_AW];
            r_imm <= INST[IMM_W-1:0];
            r_fs  <= w_fs;
            r_mb  <= w_mb;
            r_md  <= w_md;
            r_ld  <= w_ld;
            r_mw  <= w_mw;
            r_ra  <= w_ra;
            r_rb  <= w_rb;
        end
    end

    // Saturating count of cycles spent blocked on a hazard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_hazard && (r_stall_count != {CNT_W{1'b1}})) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign DR          = r_dr;
    assign SA          = r_sa;
    assign SB          = r_sb;
    assign IMM         = r_imm;
    assign MB          = r_mb;
    assign FS          = r_fs;
    assign MD          = r_md;
    assign LD          = r_ld;
    assign MW          = r_mw;
    assign stall_count = r_stall_count;

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage with valid/ready handshakes and a register scoreboard. Successor to the combinational decoder: same control-word outputs (DR, SA, SB, IMM, MB, FS, MD, LD, MW), now generalised in instruction and register-address width, with an output holding register. It stalls issue on RAW/WAW hazards against in-flight register writes, which are retired by a writeback port. Sits between instruction fetch and the register-file/ALU stage.

## Interface
- INST_W, 16: instruction width; must be at least 4 + 3*REG_AW and at least IMM_W.
- REG_AW, 3: register address width; the register file has 2**REG_AW entries.
- IMM_W, 6: immediate width.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock. One clock domain; all state is updated on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- in_valid  in  1  fetch presents INST.
- in_ready  out  1  stage accepts INST this cycle.
- INST  in  INST_W  instruction.
- flush  in  1  discard the held instruction.
- out_valid  out  1  decoded word valid and hazard-free.
- out_ready  in  1  downstream accepts.
- DR, SA, SB  out  REG_AW each  destination, read A and read B addresses.
- IMM  out  IMM_W  raw immediate.
- MB  out  1  ALU B-input mux select; 1 selects IMM.
- FS  out  3  ALU function select.
- MD  out  1  writeback source; 1 selects data memory.
- LD  out  1  register-file write enable.
- MW  out  1  memory write enable.
- wb_valid  in  1  a register write retires this cycle.
- wb_addr  in  REG_AW  register being retired.
- stall_count  out  CNT_W  cycles with held entry and hazard; saturating.

## Operation
Fields, with OP = INST[INST_W-1 -: 4]:
- DR = next REG_AW bits below OP; SA follows DR; SB follows SA.
- IMM = INST[IMM_W-1:0].
- With the default widths: OP[15:12], DR[11:9], SA[8:6], SB[5:3], IMM[5:0].

Decode by OP:
- 0000: NOP. All controls 0; reads and writes no register.
- 0fff, fff≠000: ALU register op. FS=fff, MB=0, MD=0, LD=1, MW=0. Reads SA and SB.
- 1fff, fff∉{110,111}: ALU immediate op. FS=fff, MB=1, MD=0, LD=1. Reads SA.
- 1110: LOAD. FS=000, MB=1, MD=1, LD=1. Reads SA.
- 1111: STORE. FS=000, MB=1, MD=0, LD=0, MW=1. Reads SA and SB.

Scoreboard:
- `pend` holds one bit per register.
- Effective set `eff = pend & ~(wb_valid ? onehot(wb_addr) : 0)`, i.e. a same-cycle writeback bypasses.
- hazard = held & ((readsA & eff[SA]) | (readsB & eff[SB]) | (LD & eff[DR])).
- out_valid = held & ~hazard.
- in_ready = ~held | (out_valid & out_ready).
- On issue (out_valid & out_ready) with LD=1, set pend[DR]. If the same cycle also retires DR, the set wins.
- wb_valid clears pend[wb_addr]. A retire to a register that is not pending is ignored.

Flush:
- flush clears `held` and suppresses this cycle's accept; in_ready reads 0 while flush is high.
- pend is unchanged by flush.
- An issue in the same cycle as flush still completes; out_valid is computed before the flush takes effect.

## Timing
- Latency: INST accepted at edge N appears on the outputs after edge N, with out_valid high in cycle N+1 if there is no hazard.
- Throughput: one instruction per cycle when there are no hazards.
- Decoded outputs are registered. They hold stable while held & ~out_ready, and while stalled on a hazard.
- Reset: held=0, pend=0, stall_count=0, out_valid=0, in_ready=1, and every decoded output is 0.
- Reset asserted mid-operation drops the held instruction and all pend bits immediately, without waiting for a clock edge.
- stall_count increments in each cycle where held & hazard, and saturates at all-ones.

## Test plan
- Reset with in_valid=1 and INST=0x1298 → all outputs 0 and in_ready=1 while rst is high. On the first edge after release: DR=1, SA=2, SB=3, FS=001, LD=1, MB=0, out_valid=1.
- 0x1298 issued, then 0x1840 (reads R1) with no writeback → out_valid=0 and stall_count counts. When wb_valid=1 with wb_addr=1, out_valid=1 in that same cycle (bypass).
- Back-to-back independent instructions 0xEA84 then 0xF0EF, with out_ready=1:
  - 0xEA84 → DR=5, SA=2, IMM=4, MD=1, MB=1.
  - 0xF0EF → SA=3, SB=5, IMM=0x2F, MW=1, LD=0. It stalls on R5 until wb_addr=5 retires.
- out_ready held 0 for 3 cycles with a valid entry → all outputs stable, in_ready=0, pend unchanged.
- flush while an entry is held and blocked → held clears, next cycle in_ready=1, pend unchanged.
- Issue of a write to DR=4 in the same cycle as wb_addr=4 → pend[4]=1 afterwards. NOP 0x0000 → out_valid next cycle, pend unchanged.
